fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the RISC-V core. It owns the fetch PC and drives a request/acknowledge instruction-memory port. It holds each fetched word in a single-entry IF/ID register that feeds decode, where the instruction reaches the Sign_Extend immediate generator. On a taken branch it computes the target from decode's sign-extended immediate, squashes the wrong-path fetch and redirects.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- NOP_INST, 32'h0000_0013, value of inst_o when empty (addi x0,x0,0)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous and active-high
- imem_req_o  out  1  instruction-memory request
- imem_addr_o  out  32  request byte address
- imem_ack_i  in  1  memory returns data for the current request
- imem_data_i  in  32  instruction word, valid with imem_ack_i
- inst_o  out  32  IF/ID instruction
- pc_o  out  32  PC of inst_o
- valid_o  out  1  IF/ID register holds a live instruction
- ready_i  in  1  decode consumes inst_o this cycle when valid_o=1
- branch_i  in  1  taken branch resolved this cycle (redirect + flush)
- branch_pc_i  in  32  PC of the branch instruction
- imm_i  in  32  sign-extended B-type immediate, halfword units (Sign_Extend output)

## Operation
- Registers: fetch_pc, req_addr, state {RUN, WAIT, DROP}, valid_o, inst_o, pc_o.
- room = !valid_o || ready_i.
- Branch target: branch_pc_i + {imm_i[30:0],1'b0}, mod 2^32. No alignment check; the address is driven as computed.
- RUN:
  - imem_req_o = room; imem_addr_o = fetch_pc.
  - req & ack: load IF/ID (inst_o=imem_data_i, pc_o=fetch_pc, valid_o=1); fetch_pc += 4.
  - req & !ack: req_addr <= fetch_pc; go to WAIT.
- WAIT:
  - imem_req_o = 1; imem_addr_o = req_addr, held stable.
  - ack: load IF/ID with pc_o=req_addr; fetch_pc = req_addr+4; go to RUN.
  - Room is guaranteed, because there is only one outstanding request.
- DROP:
  - imem_req_o = 1; imem_addr_o = req_addr. The squashed request is held until acknowledged.
  - ack: discard the data, no IF/ID load; go to RUN.
- Redirect (branch_i=1, any state):
  - fetch_pc <= target; valid_o <= 0; inst_o <= NOP_INST; pc_o unchanged.
  - Any ack this cycle is discarded.
  - If a request remains unacked after this cycle (RUN with req&!ack, WAIT/DROP without ack): req_addr keeps the old address, go to DROP. Otherwise go to RUN.
- Consumption: valid_o & ready_i with no load clears valid_o. A load and a consume in the same cycle replace the entry.
- Priority: rst_i > branch_i > imem_ack_i > ready_i.
- Reset: fetch_pc=RESET_PC, state=RUN, valid_o=0, inst_o=NOP_INST, pc_o=0. Any outstanding request is abandoned; the memory is reset in the same cycle.

## Timing
- imem_req_o and imem_addr_o are combinational from state/valid_o/ready_i/fetch_pc. imem_req_o in RUN depends on ready_i; there is no path from imem_ack_i to req/addr.
- First request is in the first cycle after rst_i deasserts.
- Ack in cycle t gives valid_o=1 in t+1.
- Zero-wait memory with ready_i=1: one instruction per cycle.
- N-cycle ack latency: one instruction per N+1 cycles.
- Redirect in cycle t gives valid_o=0 in t+1.
  - From RUN/no outstanding request: target requested in t+1.
  - From DROP: target requested the cycle after the squashed ack.
- Once asserted without ack, req is never withdrawn and its address never changes (except by reset).

## Test plan
- Reset, RESET_PC=0, zero-wait memory returning data=addr^32'hA5A5_0000, ready_i=1 -> addresses 0,4,8,... on consecutive cycles; pc_o 0,4,8 from cycle 1; inst_o matches data; valid_o stays 1.
- ready_i low 3 cycles while valid_o=1 -> imem_req_o=0; inst_o/pc_o stable. ready_i high -> next pc_o is previous+4, no skip or duplicate.
- Memory acks 2 cycles after req -> imem_addr_o stable across the wait; valid_o pulses once per 3 cycles with pc_o 0,4,8.
- branch_i with branch_pc_i=0x10, imm_i=0xFFFF_FFFC (zero-wait) -> next cycle valid_o=0, inst_o=0x0000_0013, imem_addr_o=0x08. Next valid pc_o=0x08.
- branch_i in WAIT (req at 0x0C, ack 2 cycles later), branch_pc_i=0x04, imm_i=0x20 -> addr 0x0C held until ack; that data never appears on inst_o; next request to 0x44, pc_o=0x44.
- rst_i asserted mid-WAIT with valid_o=1 -> next cycle valid_o=0, inst_o=NOP_INST, state RUN. First post-reset request addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, drives a req/ack imem port and a single-entry IF/ID register.
// Latency: ack in cycle t gives valid_o in t+1; decode stalls via ready_i; a taken branch squashes and redirects.
// Backpressure: no new request while IF/ID is full and not consumed; an unacked request is never withdrawn.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i,
    input  logic        branch_i,
    input  logic [31:0] branch_pc_i,
    input  logic [31:0] imm_i
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] req_addr, req_addr_nxt;
    logic        valid_nxt;
    logic [31:0] inst_nxt, pc_nxt;
    logic        load;
    logic [31:0] load_pc;
    logic        room;
    logic [31:0] target;

    assign room   = !valid_o || ready_i;
    // Immediate is in halfword units; the shift drops imm_i[31], matching mod-2^32 arithmetic.
    assign target = branch_pc_i + (imm_i << 1);

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_addr_nxt = req_addr;
        valid_nxt    = valid_o;
        inst_nxt     = inst_o;
        pc_nxt       = pc_o;
        load         = 1'b0;
        load_pc      = fetch_pc;
        imem_req_o   = 1'b1;
        imem_addr_o  = req_addr;

        if (state == S_RUN) begin
            imem_req_o  = room;
            imem_addr_o = fetch_pc;
        end

        if (branch_i) begin
            fetch_pc_nxt = target;
            valid_nxt    = 1'b0;
            inst_nxt     = NOP_INST;
            // An unacked request must still be seen through, so park it in DROP.
            if (imem_req_o && !imem_ack_i) begin
                state_nxt = S_DROP;
                if (state == S_RUN) begin
                    req_addr_nxt = fetch_pc;
                end
            end else begin
                state_nxt = S_RUN;
            end
        end else begin
            case (state)
                S_RUN: begin
                    if (imem_req_o) begin
                        if (imem_ack_i) begin
                            load         = 1'b1;
                            load_pc      = fetch_pc;
                            fetch_pc_nxt = fetch_pc + 32'd4;
                        end else begin
                            req_addr_nxt = fetch_pc;
                            state_nxt    = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_ack_i) begin
                        load         = 1'b1;
                        load_pc      = req_addr;
                        fetch_pc_nxt = req_addr + 32'd4;
                        state_nxt    = S_RUN;
                    end
                end
                S_DROP: begin
                    if (imem_ack_i) begin
                        state_nxt = S_RUN;
                    end
                end
                default: state_nxt = S_RUN;
            endcase

            if (load) begin
                valid_nxt = 1'b1;
                inst_nxt  = imem_data_i;
                pc_nxt    = load_pc;
            end else if (valid_o && ready_i) begin
                valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_RUN;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            valid_o  <= 1'b0;
            inst_o   <= NOP_INST;
            pc_o     <= 32'd0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_addr <= req_addr_nxt;
            valid_o  <= valid_nxt;
            inst_o   <= inst_nxt;
            pc_o     <= pc_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural imem with programmable ack latency,
// expected IF/ID entries queued by the stimulus and checked by a monitor on each consume.
module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = 32'd0;
    logic [31:0] inst_o, pc_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic        branch_i = 1'b0;
    logic [31:0] branch_pc_i = 32'd0;
    logic [31:0] imm_i = 32'd0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t exp_q[$];
    int     total = 0;
    int     bad = 0;
    int     mem_lat = 0;
    int     wait_cnt = 0;

    fetch_stage dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_ack_i  (imem_ack_i),
        .imem_data_i (imem_data_i),
        .inst_o      (inst_o),
        .pc_o        (pc_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .branch_i    (branch_i),
        .branch_pc_i (branch_pc_i),
        .imm_i       (imm_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] addr);
        entry_t e;
        e.pc   = addr;
        e.inst = addr ^ KEY;
        exp_q.push_back(e);
    endtask

    // Inputs change at negedge; the cycle's outputs are checked 3 time units later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #3;
    endtask

    // Memory: acks a request once it has been pending mem_lat cycles.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            imem_ack_i  = imem_req_o && (wait_cnt >= mem_lat);
            imem_data_i = imem_addr_o ^ KEY;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (rst_i || !imem_req_o || imem_ack_i) wait_cnt = 0;
            else wait_cnt = wait_cnt + 1;
        end
    end

    // Scoreboard monitor: every consumed IF/ID entry must match the head of the queue.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_i && valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_consume: got pc %h, nothing expected", pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("consume_pc", pc_o, e.pc);
                    chk("consume_inst", inst_o, e.inst);
                end
            end
        end
    end

    initial begin
        // Reset
        step(); settle();
        step(); settle();
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_pc", pc_o, 32'd0);

        // Zero-wait streaming, one instruction per cycle
        step(); rst_i = 1'b0; settle();
        chk("first_req", {31'd0, imem_req_o}, 32'd1);
        chk("first_addr", imem_addr_o, 32'd0);
        push(32'd0);
        for (int i = 1; i < 6; i++) begin
            step(); settle();
            chk("stream_addr", imem_addr_o, 32'(4 * i));
            chk("stream_valid", {31'd0, valid_o}, 32'd1);
            push(32'(4 * i));
        end

        // Decode stall: no request, entry held
        for (int i = 0; i < 3; i++) begin
            step(); ready_i = 1'b0; settle();
            chk("stall_req", {31'd0, imem_req_o}, 32'd0);
            chk("stall_pc", pc_o, 32'd20);
            chk("stall_inst", inst_o, 32'd20 ^ KEY);
        end
        step(); ready_i = 1'b1; settle();
        chk("resume_addr", imem_addr_o, 32'd24);
        push(32'd24);

        // Two-cycle ack latency: address held, one instruction per three cycles
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                step(); mem_lat = 2; settle();
                chk("wait_addr", imem_addr_o, 32'(28 + 4 * i));
                chk("wait_valid", {31'd0, valid_o}, (j == 0) ? 32'd1 : 32'd0);
                if (j == 2) push(32'(28 + 4 * i));
            end
        end

        // Redirect from RUN: 0x10 + (-4 << 1) = 0x08
        step(); mem_lat = 0; settle();
        chk("pre_br_addr", imem_addr_o, 32'd40);
        push(32'd40);
        step(); branch_i = 1'b1; branch_pc_i = 32'h10; imm_i = 32'hFFFF_FFFC; settle();
        chk("br_squash_addr", imem_addr_o, 32'd44);
        step(); branch_i = 1'b0; settle();
        chk("br_valid", {31'd0, valid_o}, 32'd0);
        chk("br_inst", inst_o, NOP);
        chk("br_pc_kept", pc_o, 32'd40);
        chk("br_target", imem_addr_o, 32'h08);
        push(32'h08);

        // Redirect while waiting: squashed 0x0C held to ack, then 0x04 + (0x20 << 1) = 0x44
        step(); mem_lat = 2; settle();
        chk("br2_valid", {31'd0, valid_o}, 32'd1);
        chk("br2_req_addr", imem_addr_o, 32'h0C);
        step(); branch_i = 1'b1; branch_pc_i = 32'h04; imm_i = 32'h20; settle();
        chk("br2_hold_addr", imem_addr_o, 32'h0C);
        step(); branch_i = 1'b0; settle();
        chk("drop_req", {31'd0, imem_req_o}, 32'd1);
        chk("drop_addr", imem_addr_o, 32'h0C);
        chk("drop_valid", {31'd0, valid_o}, 32'd0);
        chk("drop_inst", inst_o, NOP);
        step(); mem_lat = 0; settle();
        chk("after_drop_valid", {31'd0, valid_o}, 32'd0);
        chk("br2_target", imem_addr_o, 32'h44);
        push(32'h44);
        step(); mem_lat = 2; settle();
        chk("br2_pc", pc_o, 32'h44);
        chk("pre_rst_addr", imem_addr_o, 32'h48);

        // Reset mid-WAIT
        step(); rst_i = 1'b1; settle();
        chk("midwait_addr", imem_addr_o, 32'h48);
        step(); rst_i = 1'b0; mem_lat = 0; settle();
        chk("rst2_valid", {31'd0, valid_o}, 32'd0);
        chk("rst2_inst", inst_o, NOP);
        chk("rst2_addr", imem_addr_o, 32'd0);
        push(32'd0);
        step(); branch_i = 1'b1; branch_pc_i = 32'd0; imm_i = 32'd0; settle();
        chk("rst2_pc", pc_o, 32'd0);
        chk("rst2_load_valid", {31'd0, valid_o}, 32'd1);
        step(); branch_i = 1'b0; ready_i = 1'b0; settle();
        chk("end_valid", {31'd0, valid_o}, 32'd0);
        step(); settle();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
